// File: rtl/sync_fifo_if.sv
// Write/read handshake bundle for sync_fifo; the FIFO sits on the slave side.
interface sync_fifo_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  w_valid;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  w_ready;
  logic                  r_ready;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;

  modport master (
    output w_valid, w_data, r_ready,
    input  w_ready, r_valid, r_data
  );

  modport slave (
    input  w_valid, w_data, r_ready,
    output w_ready, r_valid, r_data
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with registered full/empty/level and threshold flags.
// Optional SYNC_FIFO_WATERMARK_EN adds max_level, the peak occupancy since reset.
module sync_fifo #(
  parameter int DATA_WIDTH    = 8,
  parameter int DEPTH         = 16,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 2,
  localparam int ADDR_WIDTH   = $clog2(DEPTH),
  localparam int LVL_WIDTH    = ADDR_WIDTH + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  sync_fifo_if.slave           bus,
  output logic [LVL_WIDTH-1:0] level,
  output logic                 almost_full,
  output logic                 almost_empty
`ifdef SYNC_FIFO_WATERMARK_EN
  , output logic [LVL_WIDTH-1:0] max_level
`endif
);

  localparam logic [LVL_WIDTH-1:0] MSB_ONLY = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [LVL_WIDTH-1:0] ONE      = LVL_WIDTH'(1);
  localparam logic [LVL_WIDTH-1:0] AF_LVL   = LVL_WIDTH'(AFULL_THRESH);
  localparam logic [LVL_WIDTH-1:0] AE_LVL   = LVL_WIDTH'(AEMPTY_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [LVL_WIDTH-1:0]  wptr, rptr, wptr_nxt, rptr_nxt, level_nxt;
  logic                  empty, full;
  logic                  w_en, r_en;

  assign w_en = bus.w_valid & ~full;
  assign r_en = bus.r_ready & ~empty;

  assign bus.w_ready = ~full;
  assign bus.r_valid = ~empty;
  assign bus.r_data  = mem[rptr[ADDR_WIDTH-1:0]];

  always_comb begin
    wptr_nxt  = wptr;
    rptr_nxt  = rptr;
    level_nxt = level;
    if (flush) begin
      wptr_nxt  = '0;
      rptr_nxt  = '0;
      level_nxt = '0;
    end else begin
      if (w_en) wptr_nxt = wptr + ONE;
      if (r_en) rptr_nxt = rptr + ONE;
      case ({w_en, r_en})
        2'b10:   level_nxt = level + ONE;
        2'b01:   level_nxt = level - ONE;
        default: level_nxt = level;
      endcase
    end
  end

  // Flags are computed from next-state pointers so they stay in step with level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr         <= '0;
      rptr         <= '0;
      level        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      wptr         <= wptr_nxt;
      rptr         <= rptr_nxt;
      level        <= level_nxt;
      empty        <= (wptr_nxt == rptr_nxt);
      full         <= ((wptr_nxt ^ rptr_nxt) == MSB_ONLY);
      almost_full  <= (level_nxt >= AF_LVL);
      almost_empty <= (level_nxt <= AE_LVL);
    end
  end

  // Storage is never reset; writes are suppressed during reset and flush.
  always_ff @(posedge clk) begin
    if (rst_n && !flush && w_en)
      mem[wptr[ADDR_WIDTH-1:0]] <= bus.w_data;
  end

`ifdef SYNC_FIFO_WATERMARK_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      max_level <= '0;
    else if (level > max_level)
      max_level <= level;
  end
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo (DEPTH=16, DATA_WIDTH=8): vector table plus corner sequences.
module tb_sync_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic [4:0] level;
  logic       almost_full, almost_empty;
`ifdef SYNC_FIFO_WATERMARK_EN
  logic [4:0] max_level;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;

  sync_fifo_if #(.DATA_WIDTH(8)) bus ();

  sync_fifo #(
    .DATA_WIDTH(8),
    .DEPTH(16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .bus          (bus),
    .level        (level),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
`ifdef SYNC_FIFO_WATERMARK_EN
    , .max_level  (max_level)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       flush;
    logic       w_valid;
    logic [7:0] w_data;
    logic       r_ready;
    logic       exp_w_ready;
    logic       exp_r_valid;
    logic       chk_data;
    logic [7:0] exp_r_data;
    logic [4:0] exp_level;
    logic       exp_af;
    logic       exp_ae;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string tag, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic expect_state(input string tag, input logic wr, input logic rv,
                              input logic [4:0] lv, input logic af, input logic ae);
    chk({tag, " w_ready"}, 32'(bus.w_ready), 32'(wr));
    chk({tag, " r_valid"}, 32'(bus.r_valid), 32'(rv));
    chk({tag, " level"}, 32'(level), 32'(lv));
    chk({tag, " almost_full"}, 32'(almost_full), 32'(af));
    chk({tag, " almost_empty"}, 32'(almost_empty), 32'(ae));
  endtask

  task automatic step(input logic fl, input logic wv, input logic [7:0] wd, input logic rr);
    flush       = fl;
    bus.w_valid = wv;
    bus.w_data  = wd;
    bus.r_ready = rr;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic wv, input logic [7:0] wd, input logic rr,
                              input logic wr, input logic rv, input logic cd,
                              input logic [7:0] rd, input int lv);
    vec_t v;
    v.flush       = 1'b0;
    v.w_valid     = wv;
    v.w_data      = wd;
    v.r_ready     = rr;
    v.exp_w_ready = wr;
    v.exp_r_valid = rv;
    v.chk_data    = cd;
    v.exp_r_data  = rd;
    v.exp_level   = 5'(lv);
    v.exp_af      = (lv >= 14);
    v.exp_ae      = (lv <= 2);
    return v;
  endfunction

  initial begin
    // Fill 0x01..0x10 with the consumer stalled, then one dropped write at full.
    for (int k = 1; k <= 16; k++)
      vecs.push_back(mk(1'b1, 8'(k), 1'b0, (k < 16), 1'b1, 1'b1, 8'h01, k));
    vecs.push_back(mk(1'b1, 8'hAA, 1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 16));
    // Drain: after the k-th pop the head is k+1.
    for (int k = 1; k <= 16; k++)
      vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, (k < 16), (k < 16), 8'(k + 1), 16 - k));
    // Write into empty with r_ready high: visible next cycle, popped the one after.
    vecs.push_back(mk(1'b1, 8'h5A, 1'b1, 1'b1, 1'b1, 1'b1, 8'h5A, 1));
    vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 0));

    rst_n = 1'b0;
    step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    expect_state("reset", 1'b1, 1'b0, 5'd0, 1'b0, 1'b1);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].flush, vecs[i].w_valid, vecs[i].w_data, vecs[i].r_ready);
      expect_state($sformatf("vec%0d", i), vecs[i].exp_w_ready, vecs[i].exp_r_valid,
                   vecs[i].exp_level, vecs[i].exp_af, vecs[i].exp_ae);
      if (vecs[i].chk_data)
        chk($sformatf("vec%0d r_data", i), 32'(bus.r_data), 32'(vecs[i].exp_r_data));
    end

    // Level 8 then 40 simultaneous transfers across the pointer wrap.
    for (int k = 0; k < 8; k++)
      step(1'b0, 1'b1, 8'(100 + k), 1'b0);
    expect_state("fill8", 1'b1, 1'b1, 5'd8, 1'b0, 1'b0);
    chk("fill8 r_data", 32'(bus.r_data), 32'd100);
    for (int j = 0; j < 40; j++) begin
      step(1'b0, 1'b1, 8'(108 + j), 1'b1);
      chk($sformatf("wrap%0d level", j), 32'(level), 32'd8);
      chk($sformatf("wrap%0d r_data", j), 32'(bus.r_data), 32'(101 + j));
    end
    expect_state("wrap end", 1'b1, 1'b1, 5'd8, 1'b0, 1'b0);

    // Level 10, then flush with both transfers requested.
    step(1'b0, 1'b1, 8'd148, 1'b0);
    step(1'b0, 1'b1, 8'd149, 1'b0);
    expect_state("lvl10", 1'b1, 1'b1, 5'd10, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'hEE, 1'b1);
    expect_state("flush", 1'b1, 1'b0, 5'd0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 8'h33, 1'b0);
    expect_state("post flush", 1'b1, 1'b1, 5'd1, 1'b0, 1'b1);
    chk("post flush r_data", 32'(bus.r_data), 32'h33);

    // Reset at level 5 with transfers requested.
    for (int k = 0; k < 4; k++)
      step(1'b0, 1'b1, 8'(8'h34 + k), 1'b0);
    expect_state("lvl5", 1'b1, 1'b1, 5'd5, 1'b0, 1'b0);
    rst_n = 1'b0;
    step(1'b0, 1'b1, 8'h99, 1'b1);
    expect_state("mid reset", 1'b1, 1'b0, 5'd0, 1'b0, 1'b1);
    rst_n = 1'b1;
    step(1'b0, 1'b1, 8'h77, 1'b0);
    expect_state("first after reset", 1'b1, 1'b1, 5'd1, 1'b0, 1'b1);
    chk("first after reset r_data", 32'(bus.r_data), 32'h77);

`ifdef SYNC_FIFO_WATERMARK_EN
    rst_n = 1'b0;
    step(1'b0, 1'b0, 8'h00, 1'b0);
    rst_n = 1'b1;
    chk("wm reset", 32'(max_level), 32'd0);
    for (int k = 0; k < 12; k++)
      step(1'b0, 1'b1, 8'(k), 1'b0);
    for (int k = 0; k < 12; k++)
      step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    chk("wm after flush", 32'(max_level), 32'd12);
    rst_n = 1'b0;
    step(1'b0, 1'b0, 8'h00, 1'b0);
    rst_n = 1'b1;
    chk("wm after reset", 32'(max_level), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, payload width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 16, entry count, power of 2 and >=2; ADDR_WIDTH = log2(DEPTH), LVL_WIDTH = ADDR_WIDTH+1.
REQ-003 SHALL have parameter AFULL_THRESH, default DEPTH-2, almost-full level threshold.
REQ-004 SHALL have parameter AEMPTY_THRESH, default 2, almost-empty level threshold.
REQ-005 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n  input  1  reset; synchronous and active-low.
REQ-007 SHALL have port flush  input  1  synchronous discard of all stored entries.
REQ-008 SHALL have port w_valid  input  1  write request.
REQ-009 SHALL have port w_data  input  DATA_WIDTH  write payload.
REQ-010 SHALL have port w_ready  output  1  space available (= ~full).
REQ-011 SHALL have port r_ready  input  1  consumer accepts head entry.
REQ-012 SHALL have port r_valid  output  1  head entry present (= ~empty).
REQ-013 SHALL have port r_data  output  DATA_WIDTH  head entry, show-ahead.
REQ-014 SHALL have port level  output  LVL_WIDTH  current occupancy, 0..DEPTH.
REQ-015 SHALL have ports almost_full, almost_empty  output  1  threshold flags.

Function
REQ-016 Write transfer w_en = w_valid & w_ready; read transfer r_en = r_valid & r_ready; only transfers change state.
REQ-017 Storage SHALL be DEPTH x DATA_WIDTH, written on clk at wptr[ADDR_WIDTH-1:0] when w_en; read combinationally at rptr[ADDR_WIDTH-1:0].
REQ-018 wptr/rptr SHALL be LVL_WIDTH binary counters, +1 per transfer, wrapping modulo 2*DEPTH.
REQ-019 empty SHALL be registered: true when next wptr == next rptr.
REQ-020 full SHALL be registered: true when next pointers differ only in MSB.
REQ-021 level SHALL be registered: +1 on w_en only, -1 on r_en only, unchanged on both or neither.
REQ-022 almost_full SHALL be registered as (next level >= AFULL_THRESH); almost_empty as (next level <= AEMPTY_THRESH).
REQ-023 Write-to-read latency SHALL be 1 cycle: entry written at edge N is visible (r_valid=1, r_data valid) after edge N.
REQ-024 Full: w_ready=0, w_valid ignored, storage unchanged; simultaneous r_en frees one slot, w_ready=1 next cycle.
REQ-025 Empty: r_valid=0, r_ready ignored; simultaneous w_en makes r_valid=1 next cycle; r_data undefined while empty.
REQ-026 Simultaneous w_en and r_en at any non-empty, non-full level SHALL keep level, full, empty unchanged.
REQ-027 flush=1 SHALL at next edge set wptr=rptr=0, level=0, empty=1, full=0, almost_empty=1, almost_full=0; overrides same-cycle w_en/r_en (neither takes effect); storage contents not cleared.
REQ-028 Order SHALL be strict FIFO across pointer wrap-around; no entry lost or duplicated.

Reset
REQ-029 rst_n=0 sampled at a clk edge SHALL set wptr=rptr=0, level=0, empty=1 (r_valid=0), full=0 (w_ready=1), almost_empty=1, almost_full=0.
REQ-030 Reset SHALL take priority over flush and transfers; reset mid-operation discards all entries; storage is not reset.
REQ-031 First transfer SHALL be accepted on the first edge with rst_n=1.

Configuration
REQ-032 Macro SYNC_FIFO_WATERMARK_EN defined: SHALL add output max_level (LVL_WIDTH), registered maximum of level since reset; updates the cycle after level exceeds it; reset to 0; not cleared by flush.
REQ-033 Macro SYNC_FIFO_WATERMARK_EN undefined: max_level port and logic SHALL be absent; all other behaviour identical.

Verification
REQ-034 Reset, then write 0x01..0x10 (DEPTH=16) with r_ready=0 -> w_ready=0 after 16th, level=16, almost_full=1 from level 14; 17th write 0xAA dropped.
REQ-035 From full, r_ready=1 with w_valid=0 -> r_data 0x01..0x10 in order, r_valid=0 after 16 reads, level=0, almost_empty=1 at level<=2.
REQ-036 Empty, write 0x5A at edge N with r_ready=1 -> r_valid=1, r_data=0x5A after edge N; popped at edge N+1, r_valid=0.
REQ-037 Level 8, w_valid=r_ready=1 for 40 cycles with incrementing data -> level stays 8, output in order across pointer wrap.
REQ-038 Level 10, flush=1 with w_valid=r_ready=1 -> next cycle level=0, r_valid=0, w_ready=1; no entry written or popped; rst_n=0 at level 5 gives same reset values.
REQ-039 With SYNC_FIFO_WATERMARK_EN: fill to 12, drain to 0, flush -> max_level=12; reset -> max_level=0.
